// File: rtl/bp_me_pkg.sv
// bp_me_pkg: arbiter state encoding and processor-config derived widths for the BedRock mem port arbiter
package bp_me_pkg;
  typedef enum logic {e_arb_idle, e_arb_lock} bp_me_arb_state_e;
  typedef enum logic [1:0] {e_bp_default_cfg, e_bp_small_cfg} bp_params_e;
  localparam int mem_msg_type_width_gp = 4;
  localparam int mem_msg_size_width_gp = 3;
  function automatic int paddr_width(bp_params_e cfg);
    return cfg == e_bp_small_cfg ? 32 : 40;
  endfunction
  function automatic int cce_block_width(bp_params_e cfg);
    return cfg == e_bp_small_cfg ? 64 : 512;
  endfunction
  function automatic int lce_id_width(bp_params_e cfg);
    return cfg == e_bp_small_cfg ? 2 : 4;
  endfunction
  function automatic int cce_mem_msg_width(bp_params_e cfg);
    return mem_msg_type_width_gp + mem_msg_size_width_gp + paddr_width(cfg) + lce_id_width(cfg) + cce_block_width(cfg);
  endfunction
  function automatic int safe_clog2(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bp_me_cache_arb_tag_fifo.sv
// bp_me_cache_arb_tag_fifo: async-reset source-id FIFO with registered full/empty, no push-through-pop bypass
module bp_me_cache_arb_tag_fifo
  import bp_me_pkg::*;
#(
  parameter int width_p = 1,
  parameter int depth_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               push_i,
  output logic [width_p-1:0] data_o,
  input  logic               pop_i,
  output logic               full_o,
  output logic               empty_o
);
  localparam int ptr_w = safe_clog2(depth_p);
  logic [width_p-1:0] mem [depth_p];
  logic [ptr_w-1:0] wr, rd, wr_n, rd_n;
  logic push, pop;
  assign push = push_i & ~full_o;
  assign pop = pop_i & ~empty_o;
  assign wr_n = push ? (wr == ptr_w'(depth_p-1) ? '0 : wr + 1'b1) : wr;
  assign rd_n = pop ? (rd == ptr_w'(depth_p-1) ? '0 : rd + 1'b1) : rd;
  assign data_o = mem[rd];
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      wr <= '0;
      rd <= '0;
      full_o <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      wr <= wr_n;
      rd <= rd_n;
      if (push & ~pop) begin
        full_o <= wr_n == rd;
        empty_o <= 1'b0;
      end else if (pop & ~push) begin
        empty_o <= rd_n == wr;
        full_o <= 1'b0;
      end
    end
  always_ff @(posedge clk_i)
    if (push) mem[wr] <= data_i;
endmodule

// File: rtl/bp_me_cache_port_arbiter.sv
// bp_me_cache_port_arbiter: round-robin share of one BedRock mem port with in-order response routing
// BP_ME_CACHE_ARB_STATS_EN adds saturating per-source grant counters on grant_count_o
module bp_me_cache_port_arbiter
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int num_req_p = 2,
  parameter int outstanding_p = 4,
  localparam int cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p),
  localparam int lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_req_p*cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]                      mem_cmd_v_i,
  output logic [num_req_p-1:0]                      mem_cmd_ready_and_o,
  output logic [cce_mem_msg_width_lp-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]                      mem_resp_v_o,
  input  logic [num_req_p-1:0]                      mem_resp_yumi_i,
  output logic [cce_mem_msg_width_lp-1:0]           cmd_o,
  output logic                                      cmd_v_o,
  input  logic                                      cmd_ready_and_i,
  input  logic [cce_mem_msg_width_lp-1:0]           resp_i,
  input  logic                                      resp_v_i,
  output logic                                      resp_yumi_o,
  output logic [num_req_p*32-1:0]                   grant_count_o
);
  bp_me_arb_state_e state, state_n;
  logic [lg_num_req_lp-1:0] rr_ptr, lock_id, pick, cand, sel, head;
  logic [cce_mem_msg_width_lp-1:0] cmds [num_req_p];
  logic full, empty, hs, tag_v;
  for (genvar g = 0; g < num_req_p; g++) begin : g_split
    assign cmds[g] = mem_cmd_i[g*cce_mem_msg_width_lp +: cce_mem_msg_width_lp];
  end
  // Scan from the highest offset down so the nearest valid source at or after rr_ptr wins.
  always_comb begin
    pick = rr_ptr;
    cand = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      cand = lg_num_req_lp'((int'(rr_ptr) + i) % num_req_p);
      if (mem_cmd_v_i[cand]) pick = cand;
    end
  end
  assign sel = state == e_arb_lock ? lock_id : pick;
  assign cmd_o = cmds[sel];
  assign cmd_v_o = ~reset_i & ~full & (state == e_arb_lock ? mem_cmd_v_i[lock_id] : |mem_cmd_v_i);
  assign hs = cmd_v_o & cmd_ready_and_i;
  assign mem_cmd_ready_and_o = {{(num_req_p-1){1'b0}}, hs} << sel;
  assign state_n = hs ? e_arb_idle : cmd_v_o ? e_arb_lock : state;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state <= e_arb_idle;
      rr_ptr <= '0;
      lock_id <= '0;
    end else begin
      state <= state_n;
      lock_id <= sel;
      if (hs) rr_ptr <= sel == lg_num_req_lp'(num_req_p-1) ? '0 : sel + 1'b1;
    end
  bp_me_cache_arb_tag_fifo #(.width_p(lg_num_req_lp), .depth_p(outstanding_p)) tags (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .data_i(sel),
    .push_i(hs),
    .data_o(head),
    .pop_i(resp_yumi_o),
    .full_o(full),
    .empty_o(empty)
  );
  assign tag_v = ~empty;
  assign mem_resp_o = resp_i;
  assign mem_resp_v_o = {{(num_req_p-1){1'b0}}, resp_v_i & tag_v} << head;
  assign resp_yumi_o = mem_resp_yumi_i[head] & tag_v;
`ifdef BP_ME_CACHE_ARB_STATS_EN
  logic [num_req_p-1:0][31:0] grants;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) grants <= '0;
    else
      for (int i = 0; i < num_req_p; i++)
        if (mem_cmd_ready_and_o[i] & ~&grants[i]) grants[i] <= grants[i] + 32'd1;
  assign grant_count_o = grants;
`else
  assign grant_count_o = '0;
`endif
`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(mem_resp_v_o));
  assert property (@(posedge clk_i) disable iff (reset_i) (mem_resp_yumi_i & ~mem_resp_v_o) == '0);
  assert property (@(posedge clk_i) disable iff (reset_i) resp_v_i |-> tag_v);
  assert property (@(posedge clk_i) disable iff (reset_i) state == e_arb_lock |-> mem_cmd_v_i[lock_id]);
`endif
endmodule
